// File: rtl/frame_sync_controller.sv
// Frame sync controller: tracks active video, selects raw/filtered pixels
// and issues a latency-compensated frame-reset pulse.
module frame_sync_controller #(
  parameter int HACT  = 640,
  parameter int VACT  = 480,
  parameter int LAT_W = 8
) (
  input  logic                     I_PCLK,
  input  logic                     I_RST,
  input  logic                     I_VSYNC,
  input  logic                     I_DE,
  input  logic                     I_ENABLE,
  input  logic [LAT_W-1:0]         I_LATENCY,
  output logic                     O_VRST,
  output logic                     O_BYPASS,
  output logic [$clog2(HACT)-1:0]  O_COL,
  output logic [$clog2(VACT)-1:0]  O_ROW,
  output logic                     O_FRAME_ACTIVE,
  output logic                     O_FRAME_ERR,
  output logic [7:0]               O_FRAME_CNT,
  output logic [1:0]               O_STATE
);

  localparam int CW = $clog2(HACT);
  localparam int RW = $clog2(VACT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SYNC   = 2'b01,
    S_ACTIVE = 2'b10,
    S_DONE   = 2'b11
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic             r_vs_d;
  logic             r_de_d;
  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic [LAT_W-1:0] r_lcnt;
  logic             r_pend;
  logic             r_vrst;
  logic             r_bypass;
  logic             r_active;
  logic             r_err;
  logic             r_errf;
  logic             r_bad;
  logic [7:0]       r_cnt;

  logic w_rise;
  logic w_fall;
  logic w_lcol;
  logic w_last;
  logic w_fin;
  logic w_start;
  logic w_err;
  logic w_clr;
  logic w_adv;

  assign w_rise = I_VSYNC & ~r_vs_d;
  assign w_fall = ~I_DE & r_de_d;
  assign w_lcol = (r_col == CW'(HACT - 1));
  assign w_last = w_lcol && (r_row == RW'(VACT - 1));

  // Edge samplers run through reset so no false edge appears on release
  always_ff @(posedge I_PCLK) begin
    r_vs_d <= I_VSYNC;
    r_de_d <= I_DE;
  end

  always_ff @(posedge I_PCLK) begin
    if (I_RST) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (w_rise) w_nxt = S_SYNC;
      S_SYNC:   if (I_DE) w_nxt = S_ACTIVE;
      S_ACTIVE: begin
        if (I_DE && w_last) w_nxt = S_DONE;
        else if (w_rise)    w_nxt = S_SYNC;
      end
      S_DONE:   if (w_rise) w_nxt = S_SYNC;
    endcase
  end

  // Completion wins over a coincident vsync, but the error still fires
  always_comb begin
    w_fin   = 1'b0;
    w_start = 1'b0;
    w_clr   = 1'b0;
    w_adv   = 1'b0;
    w_err   = w_rise & r_pend;
    unique case (r_state)
      S_IDLE: begin
        w_adv = 1'b0;
      end
      S_SYNC: begin
        w_start = I_DE;
        w_adv   = I_DE;
      end
      S_ACTIVE: begin
        w_fin = I_DE & w_last;
        w_adv = I_DE;
        w_clr = w_fin | w_rise;
        if (w_rise || (w_fall && r_col != '0))
          w_err = 1'b1;
      end
      S_DONE: begin
        if (I_DE && !w_rise) w_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge I_PCLK) begin
    if (I_RST || w_clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_adv) begin
      if (w_lcol) begin
        r_col <= '0;
        r_row <= (r_row == RW'(VACT - 1)) ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // A new vsync edge always restarts the countdown
  always_ff @(posedge I_PCLK) begin
    if (I_RST) begin
      r_pend <= 1'b0;
      r_lcnt <= '0;
      r_vrst <= 1'b0;
    end else if (w_rise) begin
      r_pend <= 1'b1;
      r_lcnt <= I_LATENCY;
      r_vrst <= 1'b0;
    end else if (r_pend) begin
      if (r_lcnt == '0) begin
        r_vrst <= 1'b1;
        r_pend <= 1'b0;
      end else begin
        r_lcnt <= r_lcnt - LAT_W'(1);
        r_vrst <= 1'b0;
      end
    end else begin
      r_vrst <= 1'b0;
    end
  end

  always_ff @(posedge I_PCLK) begin
    if (I_RST) begin
      r_err    <= 1'b0;
      r_bypass <= 1'b1;
      r_errf   <= 1'b0;
      r_bad    <= 1'b0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else begin
      r_err    <= w_err;
      r_active <= (w_nxt == S_ACTIVE);
      if (w_err)        r_bypass <= 1'b1;
      else if (w_start) r_bypass <= ~(I_ENABLE & ~r_errf);
      if (w_start)      r_bad <= w_err;
      else if (w_err)   r_bad <= 1'b1;
      if (w_err)                  r_errf <= 1'b1;
      else if (w_fin && !r_bad)   r_errf <= 1'b0;
      if (w_fin && !w_err && !r_bad)
        r_cnt <= r_cnt + 8'd1;
    end
  end

  assign O_VRST         = r_vrst;
  assign O_BYPASS       = r_bypass;
  assign O_COL          = r_col;
  assign O_ROW          = r_row;
  assign O_FRAME_ACTIVE = r_active;
  assign O_FRAME_ERR    = r_err;
  assign O_FRAME_CNT    = r_cnt;
  assign O_STATE        = r_state;

endmodule

// File: doc/frame_sync_controller.md
FRAME_SYNC_CONTROLLER -- requirements
Module: frame_sync_controller

Interface
REQ-001 SHALL have parameter HACT, default 640, active pixels per line.
REQ-002 SHALL have parameter VACT, default 480, active lines per frame.
REQ-003 SHALL have parameter LAT_W, default 8, width of latency field.
REQ-004 SHALL have port I_PCLK  input  1  pixel clock; all logic on rising edge.
REQ-005 SHALL have port I_RST  input  1  reset, synchronous, active-high, sampled on I_PCLK.
REQ-006 SHALL have port I_VSYNC  input  1  incoming vertical sync.
REQ-007 SHALL have port I_DE  input  1  incoming data enable.
REQ-008 SHALL have port I_ENABLE  input  1  edge-filter enable request.
REQ-009 SHALL have port I_LATENCY  input  LAT_W  filter pipeline delay in I_PCLK cycles.
REQ-010 SHALL have port O_VRST  output  1  delayed frame-reset pulse to timing generator.
REQ-011 SHALL have port O_BYPASS  output  1  1 = raw pixels, 0 = filtered pixels.
REQ-012 SHALL have port O_COL  output  clog2(HACT)  active column index.
REQ-013 SHALL have port O_ROW  output  clog2(VACT)  active row index.
REQ-014 SHALL have port O_FRAME_ACTIVE  output  1  high in ACTIVE state.
REQ-015 SHALL have port O_FRAME_ERR  output  1  one-cycle malformed-frame pulse.
REQ-016 SHALL have port O_FRAME_CNT  output  8  completed clean frames, wraps 255->0.
REQ-017 SHALL have port O_STATE  output  2  current state encoding.

Function
REQ-018 SHALL register I_VSYNC and I_DE once; edge = current sample 1, registered sample 0.
REQ-019 SHALL implement states IDLE=00, SYNC=01, ACTIVE=10, DONE=11.
REQ-020 SHALL transition IDLE->SYNC, DONE->SYNC on VSYNC rising edge.
REQ-021 SHALL transition SYNC->ACTIVE on first cycle with I_DE=1; that pixel counted as col 0 row 0.
REQ-022 SHALL, in ACTIVE, increment O_COL on each I_DE=1 cycle; at HACT-1 wrap to 0 and increment O_ROW.
REQ-023 SHALL transition ACTIVE->DONE on I_DE=1 with O_ROW=VACT-1, O_COL=HACT-1; counters return to 0.
REQ-024 SHALL flag error on DE falling edge in ACTIVE with O_COL!=0 (short/long line).
REQ-025 SHALL flag error on VSYNC rising edge in ACTIVE; next state SYNC, counters cleared.
REQ-026 SHALL flag error on I_DE=1 in DONE (extra line); state stays DONE.
REQ-027 SHALL, on error, pulse O_FRAME_ERR one cycle, set O_BYPASS=1 next cycle, set sticky err_flag.
REQ-028 SHALL, on SYNC->ACTIVE, load O_BYPASS = ~(I_ENABLE & ~err_flag); O_BYPASS otherwise unchanged except REQ-027.
REQ-029 SHALL, on ACTIVE->DONE with no error during frame, clear err_flag and increment O_FRAME_CNT.
REQ-030 SHALL sample I_LATENCY=L at each VSYNC rising edge (cycle N) and assert O_VRST for exactly one cycle at N+1+L.
REQ-031 SHALL, if a new VSYNC rising edge occurs while a O_VRST countdown pends, drop the pending pulse, restart with new L, and pulse O_FRAME_ERR.
REQ-032 SHALL make all outputs registered; O_FRAME_ACTIVE = (state==ACTIVE).
REQ-033 SHALL give error priority over completion when both occur in the same cycle (counters still clear, state DONE, no count increment).

Reset
REQ-034 SHALL, while I_RST=1, hold state IDLE, O_COL=0, O_ROW=0, O_VRST=0, O_BYPASS=1, O_FRAME_ACTIVE=0, O_FRAME_ERR=0, O_FRAME_CNT=0, err_flag=0, countdown idle.
REQ-035 SHALL abandon any frame or pending O_VRST when I_RST asserts mid-operation; first post-reset VSYNC edge restarts normally.

Verification
REQ-036 Clean 640x480 frame, I_ENABLE=1, L=5 -> O_VRST at N+6, O_BYPASS=0 from first DE, DONE after pixel 307199, O_FRAME_CNT=1.
REQ-037 Line 200 with 639 DE cycles -> O_FRAME_ERR pulse at DE fall, O_BYPASS=1; next clean frame runs bypassed, clears err_flag; following frame O_BYPASS=0.
REQ-038 VSYNC edge at row 100 -> O_FRAME_ERR, state SYNC, O_ROW=O_COL=0, O_FRAME_CNT unchanged.
REQ-039 L=0 and L=255 -> O_VRST exactly 1 and 256 cycles after edge; second edge 10 cycles after first with L=50 -> one pulse at second edge+51, O_FRAME_ERR.
REQ-040 I_RST asserted mid-line with O_VRST pending -> all outputs reset values next cycle, no O_VRST emitted.
REQ-041 256 clean frames -> O_FRAME_CNT wraps to 0; I_ENABLE=0 at frame start -> O_BYPASS=1 entire frame.
